// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into big-endian word-addressed memory cycles.
// Define MISALIGNED_SPLIT_EN to split accesses that cross a word into two memory cycles.
module load_store_unit #(
  parameter int unsigned MEMORY_DEPTH = 32768,
  localparam int unsigned AW = $clog2(MEMORY_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [0:1]    req_size,
  input  logic          req_signed,
  input  logic [0:31]   req_addr,
  input  logic [0:31]   req_wdata,
  output logic          resp_valid,
  output logic [0:31]   resp_rdata,
  output logic          resp_error,
  output logic [0:AW-1] mem_address,
  output logic [0:3]    mem_wen,
  output logic [0:31]   mem_write_data,
  input  logic [0:31]   mem_read_data
);

  typedef enum logic [2:0] {StIdle, StFirst, StSecond, StData, StResp} state_e;

  state_e state_q, state_d;

  logic       store_q, signed_q;
  logic [2:0] nbytes_q;
  logic [0:1] off_q;

  logic [2:0] req_nbytes;
  logic [0:3] req_lanes;
  logic [0:7] lane_mask;
  logic       req_split, req_err;
  logic [0:31] wdata_lj;

  // Address bits above the memory word index are ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[0:29-AW];

`ifdef MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [0:3]  wen1_q;
  logic [0:31] wdata1_q, word0_q;
  logic [0:63] wdata_win;
`else
  logic [0:31] wdata_win;
`endif

  logic [0:63] rd_win, rd_shift;
  logic [6:0]  rd_rsh;
  logic [0:31] rd_raw, rd_ext;

  // Request decode: lanes over an 8-byte window spanning word0 and word0+1.
  always_comb begin
    case (req_size)
      2'd0: begin req_nbytes = 3'd1; req_lanes = 4'b1000; wdata_lj = {req_wdata[24:31], 24'h0}; end
      2'd1: begin req_nbytes = 3'd2; req_lanes = 4'b1100; wdata_lj = {req_wdata[16:31], 16'h0}; end
      2'd2: begin req_nbytes = 3'd4; req_lanes = 4'b1111; wdata_lj = req_wdata; end
      default: begin req_nbytes = 3'd0; req_lanes = 4'b0000; wdata_lj = '0; end
    endcase
    lane_mask = {req_lanes, 4'b0000} >> req_addr[30:31];
    req_split = |lane_mask[4:7];
`ifdef MISALIGNED_SPLIT_EN
    wdata_win = {wdata_lj, 32'h0} >> {req_addr[30:31], 3'b000};
    req_err   = (req_nbytes == 3'd0);
`else
    wdata_win = wdata_lj >> {req_addr[30:31], 3'b000};
    req_err   = (req_nbytes == 3'd0) || req_split;
`endif
  end

  // Load assembly: left-align the addressed bytes, then right-justify and extend.
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    rd_win = split_q ? {word0_q, mem_read_data} : {mem_read_data, 32'h0};
`else
    rd_win = {mem_read_data, 32'h0};
`endif
    rd_shift = rd_win << {off_q, 3'b000};
    rd_rsh   = 7'd64 - {1'b0, nbytes_q, 3'b000};
    rd_raw   = 32'(rd_shift >> rd_rsh);
    case (nbytes_q)
      3'd1:    rd_ext = {{24{signed_q & rd_raw[24]}}, rd_raw[24:31]};
      3'd2:    rd_ext = {{16{signed_q & rd_raw[16]}}, rd_raw[16:31]};
      default: rd_ext = rd_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req_valid) state_d = req_err ? StResp : StFirst;
`ifdef MISALIGNED_SPLIT_EN
      StFirst:  state_d = split_q ? StSecond : (store_q ? StResp : StData);
      StSecond: state_d = store_q ? StResp : StData;
`else
      StFirst:  state_d = store_q ? StResp : StData;
`endif
      StData:   state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q        <= 1'b0;
      signed_q       <= 1'b0;
      nbytes_q       <= 3'd0;
      off_q          <= 2'd0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mem_address    <= '0;
      mem_wen        <= '0;
      mem_write_data <= '0;
`ifdef MISALIGNED_SPLIT_EN
      split_q        <= 1'b0;
      wen1_q         <= '0;
      wdata1_q       <= '0;
      word0_q        <= '0;
`endif
    end else begin
      mem_wen <= '0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            store_q    <= req_store;
            signed_q   <= req_signed;
            nbytes_q   <= req_nbytes;
            off_q      <= req_addr[30:31];
            resp_rdata <= '0;
            resp_error <= req_err;
            if (!req_err) begin
              mem_address    <= req_addr[30-AW:29];
              mem_wen        <= req_store ? lane_mask[0:3] : 4'b0000;
              mem_write_data <= wdata_win[0:31];
`ifdef MISALIGNED_SPLIT_EN
              split_q        <= req_split;
              wen1_q         <= lane_mask[4:7];
              wdata1_q       <= wdata_win[32:63];
`endif
            end
          end
        end
        StFirst: begin
`ifdef MISALIGNED_SPLIT_EN
          if (split_q) begin
            mem_address    <= mem_address + AW'(1);
            mem_wen        <= store_q ? wen1_q : 4'b0000;
            mem_write_data <= wdata1_q;
          end
`endif
        end
`ifdef MISALIGNED_SPLIT_EN
        StSecond: word0_q <= mem_read_data;
`endif
        StData:   resp_rdata <= rd_ext;
        default: ;
      endcase
    end
  end

endmodule
